// File: rtl/bus_ram_slave_pkg.sv
// Shared bus definitions for the system bus slaves: data width, RW encoding
// and the slave FSM state encoding.
package bus_ram_slave_pkg;

  localparam int BUS_W = 32;

  localparam logic BUS_RW_READ  = 1'b0;
  localparam logic BUS_RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ACK     = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM with registered read; contents survive reset.
module sp_ram
  import bus_ram_slave_pkg::*;
#(
  parameter int    ADDR_BITS = 10,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [BUS_W-1:0]     wdata,
  output logic [BUS_W-1:0]     rdata
);

  logic [BUS_W-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bus_ram_slave.sv
// Bus-slave memory: window decode, wait-state counter, single-word access
// and a one-cycle BUS_ready strobe; BUS_data is driven only in read ACK.
module bus_ram_slave
  import bus_ram_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ADDR_BITS   = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [31:0]       BUS_addr,
  inout  wire  [BUS_W-1:0]  BUS_data,
  input  logic              BUS_req,
  input  logic              BUS_RW,
  output logic              BUS_ready,
  output logic              busy
);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_in, ram_addr;
  logic                   rw_q;
  logic [BUS_W-1:0]       wdata_q, ram_wdata, rdata;
  logic                   latch, we, drive, sel;
  logic [31:0]            offset;
  logic                   unused_offset_lsb;

  assign offset            = BUS_addr - BASE_ADDR;
  assign sel               = BUS_req && ((offset >> (ADDR_BITS + 2)) == 32'd0);
  assign idx_in            = offset[ADDR_BITS+1:2];
  assign unused_offset_lsb = ^offset[1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch     = 1'b0;
    we        = 1'b0;
    ram_addr  = idx_q;
    ram_wdata = wdata_q;
    BUS_ready = 1'b0;
    drive     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel) begin
          latch     = 1'b1;
          ram_addr  = idx_in;
          ram_wdata = BUS_data;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_ACK;
            we      = (BUS_RW == BUS_RW_WRITE);
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      ST_WAIT: begin
        // A dropped request aborts before the counter is allowed to finish.
        if (!BUS_req) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = ST_ACK;
            we      = (rw_q == BUS_RW_WRITE);
          end
        end
      end
      ST_ACK: begin
        BUS_ready = 1'b1;
        drive     = (rw_q == BUS_RW_READ);
        state_d   = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!BUS_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (latch && !clr) begin
      idx_q   <= idx_in;
      rw_q    <= BUS_RW;
      wdata_q <= BUS_data;
    end
  end

  // Gating with clr discards a write whose ACK edge coincides with reset.
  sp_ram #(
    .ADDR_BITS(ADDR_BITS),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .we   (we && !clr),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(rdata)
  );

  assign busy     = (state_q != ST_IDLE);
  assign BUS_data = drive ? rdata : {BUS_W{1'bz}};

endmodule

// File: tb/tb_bus_ram_slave.sv
// Bench for bus_ram_slave: three instances (default window, offset window,
// zero wait states) driven by a bus-master model with a read scoreboard.
module tb_bus_ram_slave;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] m_addr  [3];
  logic [31:0] m_wdata [3];
  logic        m_req   [3];
  logic        m_rw    [3];
  logic        m_drv   [3];
  logic        rdy     [3];
  logic        bsy     [3];
  wire  [31:0] bd0, bd1, bd2;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb_q [$];

  always #5 clk = ~clk;

  assign bd0 = m_drv[0] ? m_wdata[0] : 32'bz;
  assign bd1 = m_drv[1] ? m_wdata[1] : 32'bz;
  assign bd2 = m_drv[2] ? m_wdata[2] : 32'bz;

  bus_ram_slave #(.BASE_ADDR(32'h0), .ADDR_BITS(10), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .clr(clr), .BUS_addr(m_addr[0]), .BUS_data(bd0),
    .BUS_req(m_req[0]), .BUS_RW(m_rw[0]), .BUS_ready(rdy[0]), .busy(bsy[0]));

  bus_ram_slave #(.BASE_ADDR(32'h1000), .ADDR_BITS(10), .WAIT_CYCLES(2)) dut1 (
    .clk(clk), .clr(clr), .BUS_addr(m_addr[1]), .BUS_data(bd1),
    .BUS_req(m_req[1]), .BUS_RW(m_rw[1]), .BUS_ready(rdy[1]), .busy(bsy[1]));

  bus_ram_slave #(.BASE_ADDR(32'h0), .ADDR_BITS(10), .WAIT_CYCLES(0)) dut2 (
    .clk(clk), .clr(clr), .BUS_addr(m_addr[2]), .BUS_data(bd2),
    .BUS_req(m_req[2]), .BUS_RW(m_rw[2]), .BUS_ready(rdy[2]), .busy(bsy[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bus_data(input int s);
    case (s)
      0:       return bd0;
      1:       return bd1;
      default: return bd2;
    endcase
  endfunction

  // Full master transaction; hold = extra cycles req stays high after ACK.
  task automatic txn(input int s, input logic [31:0] a, input logic rw,
                     input logic [31:0] wd, input int w, input int hold,
                     input logic [31:0] exp_rd, input string tag);
    int   edges  = 0;
    int   pulses = 0;
    logic seen   = 1'b0;
    if (!rw) sb_q.push_back(exp_rd);
    @(posedge clk); #1;
    m_addr[s] = a; m_rw[s] = rw; m_wdata[s] = wd; m_drv[s] = rw; m_req[s] = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); edges++;
      @(negedge clk);
      if (rdy[s]) begin
        seen = 1'b1;
        check({tag, "_lat"}, 32'(edges), 32'(w + 1));
        if (!rw) check({tag, "_rdata"}, bus_data(s), sb_q.pop_front());
      end
    end
    check({tag, "_ready_seen"}, 32'(seen), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rdy[s]) pulses++;
      if (i == hold - 1) check({tag, "_busy_release"}, 32'(bsy[s]), 32'd1);
      @(posedge clk); #1;
    end
    if (hold > 0) check({tag, "_extra_pulses"}, 32'(pulses), 32'd0);
    m_req[s] = 1'b0; m_drv[s] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_busy_idle"}, 32'(bsy[s]), 32'd0);
  endtask

  task automatic quiet(input int s, input int n, input string tag);
    int pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rdy[s]) pulses++;
    end
    check({tag, "_no_ready"}, 32'(pulses), 32'd0);
    check({tag, "_busy"}, 32'(bsy[s]), 32'd0);
  endtask

  initial begin
    logic [31:0] rv [4];
    for (int s = 0; s < 3; s++) begin
      m_addr[s] = '0; m_wdata[s] = '0; m_req[s] = 1'b0; m_rw[s] = 1'b0; m_drv[s] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("rst_ready%0d", s), 32'(rdy[s]), 32'd0);
      check($sformatf("rst_busy%0d", s), 32'(bsy[s]), 32'd0);
    end

    // Word 0 preloaded through the bus, then reset must leave it intact.
    txn(0, 32'h0, 1'b1, 32'h0ab2112a, 2, 0, 32'h0, "pre_w0");
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    txn(0, 32'h0, 1'b0, 32'h0, 2, 0, 32'h0ab2112a, "rd0");

    txn(0, 32'h10, 1'b1, 32'h0ab21123, 2, 0, 32'h0, "wr16");
    txn(0, 32'h10, 1'b0, 32'h0, 2, 0, 32'h0ab21123, "rd16");
    txn(0, 32'h0,  1'b0, 32'h0, 2, 0, 32'h0ab2112a, "rd0_again");

    // Abort: req dropped during the first WAIT cycle.
    @(posedge clk); #1;
    m_addr[0] = 32'h8; m_rw[0] = 1'b0; m_req[0] = 1'b1;
    @(posedge clk); #1 m_req[0] = 1'b0;
    quiet(0, 6, "abort");
    txn(0, 32'h8,  1'b1, 32'h0ab21129, 2, 0, 32'h0, "wr8");
    txn(0, 32'h8,  1'b0, 32'h0, 2, 0, 32'h0ab21129, "rd8");

    txn(0, 32'h10, 1'b0, 32'h0, 2, 5, 32'h0ab21123, "held");

    // Offset window: out-of-window request is ignored.
    @(posedge clk); #1;
    m_addr[1] = 32'h0; m_rw[1] = 1'b0; m_req[1] = 1'b1;
    quiet(1, 6, "outwin");
    check("outwin_bus_held_low_drive", 32'(dut1.drive), 32'd0);
    m_req[1] = 1'b0;
    txn(1, 32'h1004, 1'b1, 32'h11112222, 2, 0, 32'h0, "win_w1");
    @(posedge clk); #1;
    m_addr[1] = 32'h1004; m_rw[1] = 1'b1; m_wdata[1] = 32'hdeadbeef;
    m_drv[1] = 1'b1; m_req[1] = 1'b1;
    @(posedge clk); #1 clr = 1'b1;
    m_req[1] = 1'b0; m_drv[1] = 1'b0;
    @(posedge clk); #1 clr = 1'b0;
    quiet(1, 6, "clr_wait");
    txn(1, 32'h1004, 1'b0, 32'h0, 2, 0, 32'h11112222, "win_rd1");

    // Zero wait states.
    txn(2, 32'h4, 1'b1, 32'h0ab21124, 0, 0, 32'h0, "w0_wr4");
    txn(2, 32'h4, 1'b0, 32'h0, 0, 0, 32'h0ab21124, "w0_rd4");
    for (int i = 0; i < 4; i++) begin
      rv[i] = $urandom;
      txn(2, 32'(32 + 4 * i), 1'b1, rv[i], 0, 0, 32'h0, $sformatf("rnd_wr%0d", i));
    end
    for (int i = 0; i < 4; i++)
      txn(2, 32'(32 + 4 * i), 1'b0, 32'h0, 0, 0, rv[i], $sformatf("rnd_rd%0d", i));

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
